sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 11, width of the frequency-step address driven to Lookuptb/Rotary path.
REQ-002 Parameter: DWELL_W, default 16, width of the dwell counter in Fg_CLK cycles.
REQ-003 Fg_CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 Abort  in  1  level; forces return to IDLE.
REQ-007 Loop  in  1  1 = restart sweep from StartAddr after each completion.
REQ-008 StartAddr  in  ADDR_W  first address of sweep.
REQ-009 StopAddr  in  ADDR_W  last address of sweep; direction set by its relation to StartAddr.
REQ-010 StepSize  in  ADDR_W  address increment magnitude per step.
REQ-011 Dwell  in  DWELL_W  Fg_CLK cycles to hold each address after Ready.
REQ-012 Ready  in  1  oscillator has settled on new frequency.
REQ-013 Address  out  ADDR_W  current sweep address.
REQ-014 FreqChng  out  1  one-cycle pulse each time Address changes.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Done  out  1  one-cycle pulse when the last address has completed its dwell.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_RDY, DWELL, STEP; all outputs registered.
REQ-018 IDLE: on Start=1 and Abort=0, StartAddr, StopAddr, StepSize, Dwell, direction SHALL be latched and state -> LOAD; inputs changing afterwards SHALL NOT affect the running sweep.
REQ-019 Direction SHALL be up when StopAddr >= StartAddr, else down.
REQ-020 Latched StepSize=0 SHALL be treated as 1; latched Dwell=0 SHALL be treated as 1.
REQ-021 LOAD: Address <= StartAddr, FreqChng=1 for that one cycle, state -> WAIT_RDY.
REQ-022 WAIT_RDY: hold until Ready=1; then load dwell counter with latched Dwell, state -> DWELL; no timeout.
REQ-023 DWELL: counter decrements each cycle; Address held for exactly Dwell cycles after the cycle Ready is seen.
REQ-024 At dwell expiry with Address == latched StopAddr: Done=1 for one cycle; Loop=1 -> LOAD, Loop=0 -> IDLE.
REQ-025 At dwell expiry otherwise: state -> STEP.
REQ-026 STEP: next address computed at ADDR_W+1 bits; up: Address+StepSize, down: Address-StepSize; result past StopAddr (or overflow/underflow) SHALL saturate to StopAddr; FreqChng=1 one cycle; state -> WAIT_RDY.
REQ-027 StartAddr == StopAddr SHALL produce exactly one LOAD, one dwell, one Done.
REQ-028 Abort=1 in any state SHALL force IDLE on next edge; Address holds; no FreqChng, no Done generated that cycle; Abort beats Start.
REQ-029 Start while Busy=1 SHALL be ignored.
REQ-030 FreqChng and Done SHALL never be high in the same cycle.

Reset
REQ-031 RESET=1 SHALL immediately set state IDLE, Address=0, FreqChng=0, Busy=0, Done=0, dwell counter=0, latched config=0.
REQ-032 RESET asserted mid-sweep SHALL discard the sweep; after release, block waits for a new Start.

Verification
REQ-033 Up sweep: Start=10, Stop=40, Step=10, Dwell=3, Ready tied 1 -> Address 10,20,30,40, four FreqChng pulses, each address held 3 cycles after Ready, one Done, Busy low after.
REQ-034 Saturating down sweep: Start=100, Stop=5, Step=40 -> Address 100,60,20,5; Done once.
REQ-035 Overflow: Start=2000, Stop=2047, Step=100 (ADDR_W=11) -> Address 2000,2047; no wrap to low values.
REQ-036 Ready stall: Ready held 0 for 20 cycles after a FreqChng -> Address and state held; dwell begins only after Ready=1.
REQ-037 Abort in DWELL at Address=30 -> next cycle IDLE, Busy=0, Address=30, no Done; simultaneous Start+Abort in IDLE -> stays IDLE.
REQ-038 Loop=1, Start=Stop=7, Dwell=0 -> Address 7 repeated with FreqChng/Done alternating per 1-cycle dwell; RESET mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: steps a frequency address from StartAddr to StopAddr, waiting for the
// oscillator to settle (Ready) and dwelling a programmable number of cycles per step.
module sweep_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int DWELL_W = 16
) (
    input  logic               Fg_CLK,
    input  logic               RESET,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Loop,
    input  logic [ADDR_W-1:0]  StartAddr,
    input  logic [ADDR_W-1:0]  StopAddr,
    input  logic [ADDR_W-1:0]  StepSize,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Ready,
    output logic [ADDR_W-1:0]  Address,
    output logic               FreqChng,
    output logic               Busy,
    output logic               Done
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, DWELL, STEP} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] start_q, stop_q, step_q, addr_q, addr_d, nxt;
    logic [DWELL_W-1:0] dwell_q, cnt_q, cnt_d;
    logic up_q, fchg_q, fchg_d, done_q, done_d, busy_q, busy_d;
    logic load, expire, at_stop;
    logic [ADDR_W:0] sum, diff;

    assign load    = state_q == IDLE && Start && !Abort;
    assign expire  = state_q == DWELL && cnt_q == DWELL_W'(1);
    assign at_stop = addr_q == stop_q;
    assign sum     = {1'b0, addr_q} + {1'b0, step_q};
    assign diff    = {1'b0, addr_q} - {1'b0, step_q};
    // a borrow out of diff means the step went below zero
    assign nxt = up_q ? (sum > {1'b0, stop_q} ? stop_q : sum[ADDR_W-1:0])
                      : (diff[ADDR_W] || diff < {1'b0, stop_q} ? stop_q : diff[ADDR_W-1:0]);

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            fchg_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fchg_q  <= fchg_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            if (load) begin
                start_q <= StartAddr;
                stop_q  <= StopAddr;
                step_q  <= StepSize == '0 ? ADDR_W'(1) : StepSize;
                dwell_q <= Dwell == '0 ? DWELL_W'(1) : Dwell;
                up_q    <= StopAddr >= StartAddr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = load ? LOAD : IDLE;
            LOAD:     state_d = WAIT_RDY;
            WAIT_RDY: state_d = Ready ? DWELL : WAIT_RDY;
            DWELL:    state_d = expire ? (at_stop ? (Loop ? LOAD : IDLE) : STEP) : DWELL;
            STEP:     state_d = WAIT_RDY;
            default:  state_d = IDLE;
        endcase
        if (Abort) state_d = IDLE;
    end

    always_comb begin
        addr_d = Abort ? addr_q : state_q == LOAD ? start_q : state_q == STEP ? nxt : addr_q;
        fchg_d = !Abort && (state_q == LOAD || state_q == STEP);
        done_d = !Abort && expire && at_stop;
        cnt_d  = state_q == WAIT_RDY && Ready ? dwell_q : state_q == DWELL ? cnt_q - DWELL_W'(1) : cnt_q;
        busy_d = state_d != IDLE;
    end

    assign Address  = addr_q;
    assign FreqChng = fchg_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed scenarios for sweep_ctrl, one task per feature.
module tb_sweep_ctrl;
    localparam int AW = 11;
    localparam int DW = 16;
    logic Fg_CLK, RESET, Start, Abort, Loop, Ready;
    logic [AW-1:0] StartAddr, StopAddr, StepSize, Address;
    logic [DW-1:0] Dwell;
    logic FreqChng, Busy, Done;
    int ncmp = 0;
    int nfail = 0;
    logic [AW-1:0] addrs[$];
    int fc_cyc[$];
    int ndone, done_cyc, overlap;
    bit timeout;

    sweep_ctrl #(.ADDR_W(AW), .DWELL_W(DW)) dut (
        .Fg_CLK(Fg_CLK), .RESET(RESET), .Start(Start), .Abort(Abort), .Loop(Loop),
        .StartAddr(StartAddr), .StopAddr(StopAddr), .StepSize(StepSize), .Dwell(Dwell),
        .Ready(Ready), .Address(Address), .FreqChng(FreqChng), .Busy(Busy), .Done(Done)
    );

    initial Fg_CLK = 1'b0;
    always #5 Fg_CLK = ~Fg_CLK;

    task automatic tick();
        @(posedge Fg_CLK);
        #1;
    endtask

    task automatic setup(input int s, input int e, input int st, input int dw);
        StartAddr = AW'(s);
        StopAddr  = AW'(e);
        StepSize  = AW'(st);
        Dwell     = DW'(dw);
    endtask

    // cycle 1 is the edge that sees Start; this records from cycle 2 until Busy drops
    task automatic collect(input int maxc);
        addrs.delete();
        fc_cyc.delete();
        ndone = 0;
        overlap = 0;
        timeout = 1;
        for (int c = 2; c <= maxc; c++) begin
            tick();
            if (FreqChng) begin
                addrs.push_back(Address);
                fc_cyc.push_back(c);
            end
            if (Done) begin
                ndone++;
                done_cyc = c;
            end
            if (FreqChng && Done) overlap++;
            if (!Busy) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        Start = 0; Abort = 0; Loop = 0; Ready = 1;
        setup(0, 0, 0, 0);
        tick();
        ncmp++; if (Address !== '0) begin nfail++; $display("FAIL reset_addr: got %0d expected 0", Address); end
        ncmp++; if ({FreqChng, Busy, Done} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got %b expected 000", {FreqChng, Busy, Done}); end
        RESET = 1'b0;
        tick();
        tick();
        ncmp++; if (Busy !== 1'b0) begin nfail++; $display("FAIL reset_idle: busy %b expected 0", Busy); end
    endtask

    task automatic test_up();
        int exp_a[4] = '{10, 20, 30, 40};
        setup(10, 40, 10, 3);
        Start = 1;
        tick();
        ncmp++; if (Busy !== 1'b1) begin nfail++; $display("FAIL up_busy: got %b expected 1", Busy); end
        setup(500, 3, 1, 9);
        collect(60);
        Start = 0;
        ncmp++; if (timeout) begin nfail++; $display("FAIL up_timeout: sweep did not finish"); end
        ncmp++; if (addrs.size() != 4) begin nfail++; $display("FAIL up_count: got %0d pulses expected 4", addrs.size()); end
        else for (int i = 0; i < 4; i++) begin
            ncmp++; if (addrs[i] !== AW'(exp_a[i]) || fc_cyc[i] != 2 + 5 * i) begin
                nfail++; $display("FAIL up_step%0d: got addr %0d cyc %0d expected addr %0d cyc %0d", i, addrs[i], fc_cyc[i], exp_a[i], 2 + 5 * i);
            end
        end
        ncmp++; if (ndone != 1 || done_cyc != 21) begin nfail++; $display("FAIL up_done: got %0d at %0d expected 1 at 21", ndone, done_cyc); end
        ncmp++; if (overlap != 0) begin nfail++; $display("FAIL up_overlap: got %0d expected 0", overlap); end
        tick();
        ncmp++; if ({Busy, Done, FreqChng} !== 3'b000) begin nfail++; $display("FAIL up_after: got %b expected 000", {Busy, Done, FreqChng}); end
    endtask

    task automatic test_down();
        int exp_a[4] = '{100, 60, 20, 5};
        setup(100, 5, 40, 1);
        Start = 1;
        tick();
        Start = 0;
        collect(60);
        ncmp++; if (addrs.size() != 4) begin nfail++; $display("FAIL down_count: got %0d expected 4", addrs.size()); end
        else for (int i = 0; i < 4; i++) begin
            ncmp++; if (addrs[i] !== AW'(exp_a[i])) begin nfail++; $display("FAIL down_addr%0d: got %0d expected %0d", i, addrs[i], exp_a[i]); end
        end
        ncmp++; if (ndone != 1 || timeout) begin nfail++; $display("FAIL down_done: got %0d timeout %0d expected 1 0", ndone, timeout); end
    endtask

    task automatic test_overflow();
        setup(2000, 2047, 100, 2);
        Start = 1;
        tick();
        Start = 0;
        collect(40);
        ncmp++; if (addrs.size() != 2 || ndone != 1) begin nfail++; $display("FAIL ovf_count: got %0d pulses %0d done expected 2 1", addrs.size(), ndone); end
        else begin
            ncmp++; if (addrs[0] !== AW'(2000) || addrs[1] !== AW'(2047)) begin nfail++; $display("FAIL ovf_addr: got %0d,%0d expected 2000,2047", addrs[0], addrs[1]); end
        end
    endtask

    task automatic test_zero_cfg();
        setup(0, 2, 0, 0);
        Start = 1;
        tick();
        Start = 0;
        collect(40);
        ncmp++; if (addrs.size() != 3) begin nfail++; $display("FAIL zero_count: got %0d expected 3", addrs.size()); end
        else for (int i = 0; i < 3; i++) begin
            ncmp++; if (addrs[i] !== AW'(i) || fc_cyc[i] != 2 + 3 * i) begin
                nfail++; $display("FAIL zero_step%0d: got addr %0d cyc %0d expected %0d cyc %0d", i, addrs[i], fc_cyc[i], i, 2 + 3 * i);
            end
        end
        ncmp++; if (ndone != 1 || done_cyc != 10) begin nfail++; $display("FAIL zero_done: got %0d at %0d expected 1 at 10", ndone, done_cyc); end
    endtask

    task automatic test_single();
        setup(9, 9, 5, 2);
        Start = 1;
        tick();
        Start = 0;
        collect(30);
        ncmp++; if (addrs.size() != 1 || ndone != 1 || done_cyc != 5) begin
            nfail++; $display("FAIL single: got %0d pulses %0d done at %0d expected 1 1 at 5", addrs.size(), ndone, done_cyc);
        end
        else begin
            ncmp++; if (addrs[0] !== AW'(9)) begin nfail++; $display("FAIL single_addr: got %0d expected 9", addrs[0]); end
        end
    endtask

    task automatic test_ready_stall();
        bit held = 1;
        int seen = 0;
        Ready = 0;
        setup(3, 4, 1, 2);
        Start = 1;
        tick();
        Start = 0;
        tick();
        ncmp++; if (FreqChng !== 1'b1 || Address !== AW'(3)) begin nfail++; $display("FAIL stall_load: got fc %b addr %0d expected 1 3", FreqChng, Address); end
        repeat (20) begin
            tick();
            if (Address !== AW'(3) || FreqChng || !Busy || Done) held = 0;
        end
        ncmp++; if (!held) begin nfail++; $display("FAIL stall_hold: outputs moved while Ready=0"); end
        Ready = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (FreqChng && seen == 0) seen = i;
        end
        ncmp++; if (seen != 4 || Address !== AW'(4)) begin nfail++; $display("FAIL stall_resume: got pulse at %0d addr %0d expected 4 4", seen, Address); end
        for (int i = 0; i < 20 && Busy; i++) tick();
        ncmp++; if (Busy !== 1'b0) begin nfail++; $display("FAIL stall_end: busy %b expected 0", Busy); end
    endtask

    task automatic test_abort();
        bit found = 0;
        bit quiet = 1;
        Ready = 1;
        setup(10, 40, 10, 3);
        Start = 1;
        tick();
        Start = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (FreqChng && Address === AW'(30)) found = 1;
        end
        ncmp++; if (!found) begin nfail++; $display("FAIL abort_reach: address 30 not seen"); end
        tick();
        tick();
        Abort = 1;
        tick();
        ncmp++; if ({Busy, Done, FreqChng} !== 3'b000 || Address !== AW'(30)) begin
            nfail++; $display("FAIL abort_dwell: got bdf %b addr %0d expected 000 30", {Busy, Done, FreqChng}, Address);
        end
        Abort = 0;
        repeat (6) begin
            tick();
            if (Busy || Done || FreqChng) quiet = 0;
        end
        ncmp++; if (!quiet) begin nfail++; $display("FAIL abort_quiet: activity after abort"); end
        Start = 1;
        Abort = 1;
        tick();
        Start = 0;
        Abort = 0;
        ncmp++; if (Busy !== 1'b0) begin nfail++; $display("FAIL abort_beats_start: busy %b expected 0", Busy); end
        tick();
        ncmp++; if (Busy !== 1'b0 || FreqChng !== 1'b0) begin nfail++; $display("FAIL abort_stay_idle: got %b%b expected 00", Busy, FreqChng); end
    endtask

    task automatic test_loop_reset();
        Loop = 1;
        Ready = 1;
        setup(7, 7, 1, 0);
        Start = 1;
        tick();
        Start = 0;
        for (int c = 2; c <= 12; c++) begin
            bit fe, de;
            tick();
            fe = (c - 2) % 3 == 0;
            de = c >= 4 && (c - 4) % 3 == 0;
            ncmp++; if ({FreqChng, Done} !== {fe, de} || Address !== AW'(7)) begin
                nfail++; $display("FAIL loop_c%0d: got fc,done %b%b addr %0d expected %b%b 7", c, FreqChng, Done, Address, fe, de);
            end
        end
        ncmp++; if (Busy !== 1'b1) begin nfail++; $display("FAIL loop_busy: got %b expected 1", Busy); end
        #2 RESET = 1;
        #1;
        ncmp++; if ({Address, FreqChng, Busy, Done} !== '0) begin
            nfail++; $display("FAIL loop_reset: got addr %0d f/b/d %b%b%b expected all 0", Address, FreqChng, Busy, Done);
        end
        Loop = 0;
        #3 RESET = 0;
        repeat (5) tick();
        ncmp++; if (Busy !== 1'b0 || FreqChng !== 1'b0) begin nfail++; $display("FAIL reset_wait: got %b%b expected 00", Busy, FreqChng); end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_overflow();
        test_zero_cfg();
        test_single();
        test_ready_stall();
        test_abort();
        test_loop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
